// File: rtl/pipe_stage_buffer.sv
// Inter-stage pipeline buffer: one registered entry (payload, write control, valid)
// steered by the global stall vector and flush, with saturating bubble/hold debug counters.
module pipe_stage_buffer #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 5,
  parameter int STALL_W    = 6,
  parameter int STAGE_IDX  = 2,
  parameter int CLEAR_DATA = 1,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STALL_W-1:0] stall_en,
  input  logic               flush,
  input  logic               cnt_clr,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [ADDR_W-1:0]  in_wr_addr,
  input  logic               in_wr_en,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [ADDR_W-1:0]  out_wr_addr,
  output logic               out_wr_en,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   hold_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  if (STAGE_IDX > STALL_W-2) begin : g_bad_stage_idx
    initial $error("pipe_stage_buffer: STAGE_IDX=%0d out of range for STALL_W=%0d",
                   STAGE_IDX, STALL_W);
  end

  logic s_up;
  logic s_dn;
  logic do_clear;
  logic do_bubble;
  logic do_hold;
  logic stall_unused;

  assign s_up = stall_en[STAGE_IDX];
  assign s_dn = stall_en[STAGE_IDX+1];
  // only our two stage bits matter; the rest of the vector is deliberately ignored
  assign stall_unused = ^stall_en;

  assign do_clear  = flush | (s_up & ~s_dn);
  assign do_bubble = ~flush & s_up & ~s_dn;
  assign do_hold   = ~flush & s_up & s_dn;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_wr_addr <= '0;
      out_wr_en   <= 1'b0;
      bubble_cnt  <= '0;
      hold_cnt    <= '0;
    end else begin
      if (do_clear) begin
        out_valid   <= 1'b0;
        out_wr_en   <= 1'b0;
        out_wr_addr <= '0;
        if (CLEAR_DATA != 0) out_data <= '0;
      end else if (!s_up) begin
        // s_up=0 captures even when s_dn=1; the stall controller never issues that pair
        out_valid   <= in_valid;
        out_data    <= in_data;
        out_wr_addr <= in_wr_addr;
        out_wr_en   <= in_wr_en & in_valid;
      end

      if (cnt_clr) begin
        bubble_cnt <= '0;
        hold_cnt   <= '0;
      end else begin
        if (do_bubble && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + CNT_ONE;
        if (do_hold && (hold_cnt != '1))     hold_cnt   <= hold_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Scoreboard bench for pipe_stage_buffer: three instances (default, CLEAR_DATA=0, CNT_W=4)
// share directed stimulus; expectations are queued by the driver and popped by a monitor.
module tb_pipe_stage_buffer;

  logic        clk = 1'b0;
  logic        reset, flush, cnt_clr, in_valid, in_wr_en;
  logic [5:0]  stall_en;
  logic [63:0] in_data;
  logic [4:0]  in_wr_addr;

  logic        v0, v1, v2, we0, we1, we2;
  logic [63:0] d0, d1, d2;
  logic [4:0]  a0, a1, a2;
  logic [15:0] bc0, hc0, bc1, hc1;
  logic [3:0]  bc2, hc2;

  always #5 clk = ~clk;

  pipe_stage_buffer dut_def (
    .clk(clk), .reset(reset), .stall_en(stall_en), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_data(in_data), .in_wr_addr(in_wr_addr), .in_wr_en(in_wr_en),
    .out_valid(v0), .out_data(d0), .out_wr_addr(a0), .out_wr_en(we0),
    .bubble_cnt(bc0), .hold_cnt(hc0));

  pipe_stage_buffer #(.CLEAR_DATA(0)) dut_keep (
    .clk(clk), .reset(reset), .stall_en(stall_en), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_data(in_data), .in_wr_addr(in_wr_addr), .in_wr_en(in_wr_en),
    .out_valid(v1), .out_data(d1), .out_wr_addr(a1), .out_wr_en(we1),
    .bubble_cnt(bc1), .hold_cnt(hc1));

  pipe_stage_buffer #(.CNT_W(4)) dut_c4 (
    .clk(clk), .reset(reset), .stall_en(stall_en), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_data(in_data), .in_wr_addr(in_wr_addr), .in_wr_en(in_wr_en),
    .out_valid(v2), .out_data(d2), .out_wr_addr(a2), .out_wr_en(we2),
    .bubble_cnt(bc2), .hold_cnt(hc2));

  typedef struct {
    string       name;
    logic        v;
    logic [63:0] d;
    logic [63:0] dn;
    logic [4:0]  a;
    logic        we;
    logic [15:0] bc;
    logic [15:0] hc;
    logic [3:0]  bc4;
    logic [3:0]  hc4;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [63:0] DA = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] DB = 64'hCAFE_F00D_1234_5678;
  localparam logic [63:0] DC = 64'h1111_2222_3333_4444;
  localparam logic [63:0] DI = 64'h7777_8888_9999_AAAA;
  localparam logic [63:0] DD = 64'h0000_0000_0000_00DD;
  localparam logic [63:0] DE = 64'h0000_0000_0000_00EE;
  localparam logic [63:0] DF = 64'hF0F0_F0F0_0F0F_0F0F;
  localparam logic [63:0] DG = 64'h0BAD_C0DE_5A5A_A5A5;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic fl, input logic clr, input logic [5:0] st,
                       input logic iv, input logic [63:0] id, input logic [4:0] ia,
                       input logic iwe);
    @(negedge clk);
    reset = rst; flush = fl; cnt_clr = clr; stall_en = st;
    in_valid = iv; in_data = id; in_wr_addr = ia; in_wr_en = iwe;
  endtask

  task automatic push(input string n, input logic v, input logic [63:0] d,
                      input logic [63:0] dn, input logic [4:0] a, input logic we,
                      input logic [15:0] bc, input logic [15:0] hc,
                      input logic [3:0] bc4, input logic [3:0] hc4);
    exp_t e;
    e.name = n; e.v = v; e.d = d; e.dn = dn; e.a = a; e.we = we;
    e.bc = bc; e.hc = hc; e.bc4 = bc4; e.hc4 = hc4;
    exp_q.push_back(e);
  endtask

  // monitor: outputs settle one cycle after the stimulus, sampled just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.name, "/valid"},      v0,  e.v);
        chk({e.name, "/data"},       d0,  e.d);
        chk({e.name, "/addr"},       a0,  e.a);
        chk({e.name, "/wr_en"},      we0, e.we);
        chk({e.name, "/bubble_cnt"}, bc0, e.bc);
        chk({e.name, "/hold_cnt"},   hc0, e.hc);
        chk({e.name, "/keep_valid"}, v1,  e.v);
        chk({e.name, "/keep_data"},  d1,  e.dn);
        chk({e.name, "/keep_addr"},  a1,  e.a);
        chk({e.name, "/keep_wr_en"}, we1, e.we);
        chk({e.name, "/keep_bcnt"},  bc1, e.bc);
        chk({e.name, "/keep_hcnt"},  hc1, e.hc);
        chk({e.name, "/c4_valid"},   v2,  e.v);
        chk({e.name, "/c4_data"},    d2,  e.d);
        chk({e.name, "/c4_addr"},    a2,  e.a);
        chk({e.name, "/c4_wr_en"},   we2, e.we);
        chk({e.name, "/c4_bcnt"},    bc2, e.bc4);
        chk({e.name, "/c4_hcnt"},    hc2, e.hc4);
      end
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; cnt_clr = 1'b0; stall_en = '0;
    in_valid = 1'b0; in_data = '0; in_wr_addr = '0; in_wr_en = 1'b0;

    // reset with every input non-zero
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 1, 6'b111111, 1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 1);
      push("reset", 0, 64'h0, 64'h0, 5'd0, 0, 16'd0, 16'd0, 4'd0, 4'd0);
    end
    drive(0, 0, 0, 6'b000000, 1, 64'hDEAD_BEEF_0000_0001, 5'd7, 1);
    push("first_cap", 1, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 5'd7, 1,
         16'd0, 16'd0, 4'd0, 4'd0);

    // bubble: load A, then three bubble cycles
    drive(0, 0, 0, 6'b000000, 1, DA, 5'd3, 1);
    push("load_a", 1, DA, DA, 5'd3, 1, 16'd0, 16'd0, 4'd0, 4'd0);
    for (int i = 1; i <= 3; i++) begin
      drive(0, 0, 0, 6'b000100, 1, 64'h5555, 5'd9, 1);
      push("bubble", 0, 64'h0, DA, 5'd0, 0, 16'(i), 16'd0, 4'(i), 4'd0);
    end

    // hold: load B, then four hold cycles with changing inputs
    drive(0, 0, 0, 6'b000000, 1, DB, 5'd12, 1);
    push("load_b", 1, DB, DB, 5'd12, 1, 16'd3, 16'd0, 4'd3, 4'd0);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 0, 6'b001100, 1, 64'(i * 17), 5'd1, 1);
      push("hold", 1, DB, DB, 5'd12, 1, 16'd3, 16'(i), 4'd3, 4'(i));
    end

    // flush beats hold, then flush beats capture
    drive(0, 1, 0, 6'b001100, 1, 64'h9, 5'd1, 1);
    push("flush_hold", 0, 64'h0, DB, 5'd0, 0, 16'd3, 16'd4, 4'd3, 4'd4);
    drive(0, 1, 0, 6'b000000, 1, DC, 5'd5, 1);
    push("flush_cap", 0, 64'h0, DB, 5'd0, 0, 16'd3, 16'd4, 4'd3, 4'd4);

    // invalid entry never requests a write
    drive(0, 0, 0, 6'b000000, 0, DI, 5'd6, 1);
    push("invalid", 0, DI, DI, 5'd6, 0, 16'd3, 16'd4, 4'd3, 4'd4);

    // unrelated stall bits ignored; illegal s_up=0,s_dn=1 still captures
    drive(0, 0, 0, 6'b110011, 1, DD, 5'd2, 1);
    push("other_bits", 1, DD, DD, 5'd2, 1, 16'd3, 16'd4, 4'd3, 4'd4);
    drive(0, 0, 0, 6'b001000, 1, DE, 5'd4, 1);
    push("illegal_cap", 1, DE, DE, 5'd4, 1, 16'd3, 16'd4, 4'd3, 4'd4);

    // 20 bubbles: 4-bit counter saturates at 15, 16-bit keeps counting
    for (int i = 1; i <= 20; i++) begin
      drive(0, 0, 0, 6'b000100, 1, 64'h0, 5'd0, 1);
      push("saturate", 0, 64'h0, DE, 5'd0, 0, 16'(3 + i), 16'd4,
           (3 + i > 15) ? 4'hF : 4'(3 + i), 4'd4);
    end

    // clear wins over a same-cycle bubble increment
    drive(0, 0, 1, 6'b000100, 1, 64'h0, 5'd0, 1);
    push("clr_bubble", 0, 64'h0, DE, 5'd0, 0, 16'd0, 16'd0, 4'd0, 4'd0);
    drive(0, 0, 0, 6'b000100, 1, 64'h0, 5'd0, 1);
    push("after_clr", 0, 64'h0, DE, 5'd0, 0, 16'd1, 16'd0, 4'd1, 4'd0);

    // reset mid-hold, hold on cleared contents, then capture with cnt_clr
    drive(0, 0, 0, 6'b000000, 1, DF, 5'd17, 1);
    push("load_f", 1, DF, DF, 5'd17, 1, 16'd1, 16'd0, 4'd1, 4'd0);
    drive(0, 0, 0, 6'b001100, 1, 64'h3, 5'd3, 0);
    push("hold_f", 1, DF, DF, 5'd17, 1, 16'd1, 16'd1, 4'd1, 4'd1);
    drive(1, 0, 0, 6'b001100, 1, 64'h3, 5'd3, 0);
    push("reset_hold", 0, 64'h0, 64'h0, 5'd0, 0, 16'd0, 16'd0, 4'd0, 4'd0);
    drive(0, 0, 0, 6'b001100, 1, 64'h3, 5'd3, 0);
    push("hold_post_rst", 0, 64'h0, 64'h0, 5'd0, 0, 16'd0, 16'd1, 4'd0, 4'd1);
    drive(0, 0, 1, 6'b000000, 1, DG, 5'd21, 1);
    push("clr_cap", 1, DG, DG, 5'd21, 1, 16'd0, 16'd0, 4'd0, 4'd0);

    drive(0, 0, 0, 6'b000000, 0, 64'h0, 5'd0, 0);
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buffer.md
Name: pipe_stage_buffer

Overview:
- Parametrised inter-stage pipeline buffer; next generation of the fixed-format decode/execute buffer.
- Carries a generic payload plus a destination-write control group (address, enable) and a valid flag.
- Driven by the global stall vector from the stall controller and a flush line from branch/exception logic.
- Keeps saturating bubble and hold counters for performance debug; one instance sits between any two adjacent pipeline stages.

Parameters:
DATA_W, 64, payload width in bits (opaque to the block, e.g. alu_sel/alu_op/operands concatenated)
ADDR_W, 5, destination register address width
STALL_W, 6, width of the global stall vector
STAGE_IDX, 2, index of this buffer's upstream stage in stall_en; legal range 0..STALL_W-2
CLEAR_DATA, 1, 1: bubble/flush zeroes the payload; 0: payload holds its value, only the control fields are cleared
CNT_W, 16, width of the debug counters

Ports:
clk  input  1  clock, all state updates on the rising edge
reset  input  1  synchronous, active-high reset
stall_en  input  STALL_W  global stall vector, bit i = stage i stalled
flush  input  1  kill the entry being captured this cycle and insert a bubble
cnt_clr  input  1  synchronous clear of both debug counters
in_valid  input  1  upstream entry valid
in_data  input  DATA_W  upstream payload
in_wr_addr  input  ADDR_W  upstream destination address
in_wr_en  input  1  upstream destination write enable
out_valid  output  1  registered valid
out_data  output  DATA_W  registered payload
out_wr_addr  output  ADDR_W  registered destination address
out_wr_en  output  1  registered write enable
bubble_cnt  output  CNT_W  number of stall-induced bubbles inserted
hold_cnt  output  CNT_W  number of cycles the buffer held its contents

Behaviour:
- Only one clock and one reset: clk, with reset synchronous and active-high. No asynchronous paths; all outputs are registered.
- Let s_up = stall_en[STAGE_IDX] and s_dn = stall_en[STAGE_IDX+1].
- Evaluate the following each rising edge of clk, in priority order:
  1. reset=1: out_valid, out_data, out_wr_addr, out_wr_en, bubble_cnt and hold_cnt all go to 0.
  2. flush=1: out_valid=0, out_wr_en=0, out_wr_addr=0, and out_data=0 if CLEAR_DATA=1, else out_data holds. Flush overrides every stall combination, including a hold. No counter increments.
  3. s_up=1 and s_dn=0 (bubble): same field clearing as flush; bubble_cnt increments.
  4. s_up=0 (capture): all out_* take their in_* values. out_wr_en is forced to in_wr_en & in_valid, so an invalid entry never requests a write.
  5. s_up=1 and s_dn=1 (hold): all out_* keep their values; hold_cnt increments.
- Latency: exactly one cycle from an in_* value to out_* on capture. No combinational input-to-output path.
- Bits of stall_en other than STAGE_IDX and STAGE_IDX+1 are ignored.
- s_up=0 with s_dn=1 is an illegal combination (the stall controller never produces it). The block still performs a capture, with no assertion.
- Counters saturate at all-ones and do not wrap.
- cnt_clr=1 forces both counters to 0 and takes priority over an increment in the same cycle. cnt_clr does not affect the datapath.
- Reset asserted mid-hold or mid-bubble takes effect on that edge. Capture resumes on the first edge with reset=0 and s_up=0.
- Elaboration check: STAGE_IDX > STALL_W-2 is a configuration error, reported with $error in an initial block.

Test Plan:
- Reset: drive all inputs non-zero, reset=1 for 2 cycles -> every output reads 0; after release with stall_en=0, in_data=64'hDEAD_BEEF_0000_0001, in_wr_addr=5'd7, in_wr_en=1, in_valid=1 -> next cycle out_data=64'hDEAD_BEEF_0000_0001, out_wr_addr=7, out_wr_en=1, out_valid=1.
- Bubble: load entry A, then stall_en=6'b000100 for 3 cycles -> out_valid=0, out_wr_en=0, out_data=0 (CLEAR_DATA=1), bubble_cnt=3, hold_cnt=0. Repeat with CLEAR_DATA=0 -> out_data still equals A's payload.
- Hold: load entry B, then stall_en=6'b001100 for 4 cycles while in_data changes every cycle -> outputs stay B, hold_cnt=4, bubble_cnt unchanged.
- Flush priority: flush=1 while stall_en=6'b001100 -> out_valid=0 and out_wr_en=0 next cycle, no counter increment. flush=1 while capturing in_wr_en=1 -> out_wr_en=0.
- Invalid entry: in_valid=0, in_wr_en=1, stall_en=0 -> out_wr_en=0, out_valid=0, out_data equals in_data.
- Counters: CNT_W=4, 20 bubble cycles -> bubble_cnt=4'hF, stays 4'hF. cnt_clr=1 asserted together with a bubble cycle -> bubble_cnt=0 next cycle. Reset mid-hold -> all outputs 0 on that edge.
